// File: rtl/writeback_regfile.sv
// Writeback stage register plus 32x32 register file with two combinational read ports.
// Optional macro REGFILE_BYPASS_EN forwards the pending writeback value onto matching read ports.
module writeback_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic        wb_reg_w_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        stall,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic [31:0] rso1,
  output logic [31:0] rso2,
  output logic [31:0] alu_out,
  output logic [4:0]  alu_rd,
  output logic        alu_reg_w_en,
  output logic [31:0] wb_commit_cnt
);

  logic [31:0] regs [32];

  // Flow: a wb_* beat is accepted on every rising edge where stall=0; stall
  // acts as backpressure that freezes the stage and the register file, and
  // wb_* is ignored while it is high. An accepted entry commits on the next
  // accepting edge, which is also the edge that captures the following entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      alu_out       <= '0;
      alu_rd        <= '0;
      alu_reg_w_en  <= 1'b0;
      wb_commit_cnt <= '0;
    end else if (!stall) begin
      alu_out      <= wb_data;
      alu_rd       <= wb_rd;
      alu_reg_w_en <= wb_valid & wb_reg_w_en & (wb_rd != 5'd0);
      // alu_reg_w_en is never set for x0, so regs[0] keeps its reset value.
      if (alu_reg_w_en) begin
        regs[alu_rd]  <= alu_out;
        wb_commit_cnt <= wb_commit_cnt + 32'd1;
      end
    end
  end

  always_comb begin
    rso1 = regs[rs1];
    if (rs1 == 5'd0) rso1 = '0;
`ifdef REGFILE_BYPASS_EN
    if (alu_reg_w_en && (rs1 == alu_rd)) rso1 = alu_out;
`endif
  end

  always_comb begin
    rso2 = regs[rs2];
    if (rs2 == 5'd0) rso2 = '0;
`ifdef REGFILE_BYPASS_EN
    if (alu_reg_w_en && (rs2 == alu_rd)) rso2 = alu_out;
`endif
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed self-checking bench for writeback_regfile; expected values are hand-computed.
// Adapts the pre-commit read expectation to REGFILE_BYPASS_EN.
module tb_writeback_regfile;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic        wb_reg_w_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] rso1;
  logic [31:0] rso2;
  logic [31:0] alu_out;
  logic [4:0]  alu_rd;
  logic        alu_reg_w_en;
  logic [31:0] wb_commit_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  writeback_regfile dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_reg_w_en(wb_reg_w_en),
    .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall), .rs1(rs1), .rs2(rs2),
    .rso1(rso1), .rso2(rso2), .alu_out(alu_out), .alu_rd(alu_rd),
    .alu_reg_w_en(alu_reg_w_en), .wb_commit_cnt(wb_commit_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [4:0] rd, input logic [31:0] d);
    wb_valid    = v;
    wb_reg_w_en = w;
    wb_rd       = rd;
    wb_data     = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    rs1 = '0;
    rs2 = '0;
    idle();
    #1 rst = 1'b0;
    #10;
    rs1 = 5'd5;
    #1;
    check("rst_rso1", rso1, 32'd0);
    check("rst_alu_out", alu_out, 32'd0);
    check("rst_alu_rd", {27'd0, alu_rd}, 32'd0);
    check("rst_en", {31'd0, alu_reg_w_en}, 32'd0);
    check("rst_cnt", wb_commit_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // bypass window: rd=5 pending, old value 0
    drive(1'b1, 1'b1, 5'd5, 32'h1234_5678);
    tick();
    check("byp_alu_rd", {27'd0, alu_rd}, 32'd5);
    check("byp_en", {31'd0, alu_reg_w_en}, 32'd1);
    idle();
    rs1 = 5'd5;
    rs2 = 5'd5;
    #1;
    check("byp_rso2_pre", rso2, BYP ? 32'h1234_5678 : 32'd0);
    check("byp_same_port", rso1, BYP ? 32'h1234_5678 : 32'd0);
    tick();
    check("byp_rso2_post", rso2, 32'h1234_5678);
    check("byp_cnt", wb_commit_cnt, 32'd1);

    // write then read, rd=5
    drive(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    check("wr_alu_rd", {27'd0, alu_rd}, 32'd5);
    check("wr_en", {31'd0, alu_reg_w_en}, 32'd1);
    check("wr_alu_out", alu_out, 32'hDEAD_BEEF);
    idle();
    tick();
    check("wr_rso1", rso1, 32'hDEAD_BEEF);
    check("wr_cnt", wb_commit_cnt, 32'd2);
    check("wr_en_clear", {31'd0, alu_reg_w_en}, 32'd0);

    // back-to-back commits, no bubble
    drive(1'b1, 1'b1, 5'd10, 32'hAAAA_0010);
    exp_q.push_back(32'hAAAA_0010);
    tick();
    drive(1'b1, 1'b1, 5'd11, 32'hBBBB_0011);
    exp_q.push_back(32'hBBBB_0011);
    tick();
    check("b2b_cnt_mid", wb_commit_cnt, 32'd3);
    drive(1'b1, 1'b1, 5'd12, 32'hCCCC_0012);
    exp_q.push_back(32'hCCCC_0012);
    tick();
    idle();
    tick();
    check("b2b_cnt", wb_commit_cnt, 32'd5);
    for (int r = 10; r <= 12; r++) begin
      rs1 = 5'(r);
      rs2 = 5'(r);
      #1;
      exp_v = exp_q.pop_front();
      check("b2b_rso1", rso1, exp_v);
      check("b2b_rso2", rso2, exp_v);
    end

    // x0 and suppressed writes
    drive(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF);
    tick();
    check("x0_en", {31'd0, alu_reg_w_en}, 32'd0);
    drive(1'b0, 1'b1, 5'd3, 32'h0000_0333);
    tick();
    check("novalid_en", {31'd0, alu_reg_w_en}, 32'd0);
    drive(1'b1, 1'b0, 5'd3, 32'h0000_0333);
    tick();
    check("nowen_en", {31'd0, alu_reg_w_en}, 32'd0);
    idle();
    tick();
    rs1 = 5'd0;
    rs2 = 5'd3;
    #1;
    check("x0_rso1", rso1, 32'd0);
    check("r3_rso2", rso2, 32'd0);
    check("x0_cnt", wb_commit_cnt, 32'd5);

    // stall holds everything
    drive(1'b1, 1'b1, 5'd7, 32'h0000_00A5);
    tick();
    check("stl_capture", alu_out, 32'h0000_00A5);
    stall = 1'b1;
    rs1 = 5'd7;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b1, 5'd8, $urandom_range(32'h100, 32'hFFFF));
      tick();
      check("stl_alu_out", alu_out, 32'h0000_00A5);
      check("stl_alu_rd", {27'd0, alu_rd}, 32'd7);
      check("stl_cnt", wb_commit_cnt, 32'd5);
      check("stl_rso1", rso1, BYP ? 32'h0000_00A5 : 32'd0);
    end
    stall = 1'b0;
    idle();
    tick();
    check("stl_release", rso1, 32'h0000_00A5);
    check("stl_cnt_after", wb_commit_cnt, 32'd6);

    // async reset with a pending write
    drive(1'b1, 1'b1, 5'd9, 32'h0000_0099);
    tick();
    check("ar_pending", {31'd0, alu_reg_w_en}, 32'd1);
    idle();
    #2 rst = 1'b0;
    #1;
    rs1 = 5'd7;
    #1;
    check("ar_alu_out", alu_out, 32'd0);
    check("ar_en", {31'd0, alu_reg_w_en}, 32'd0);
    check("ar_cnt", wb_commit_cnt, 32'd0);
    check("ar_regs_clear", rso1, 32'd0);
    drive(1'b1, 1'b1, 5'd4, 32'h0000_0044);
    tick();
    check("ar_held_rd", {27'd0, alu_rd}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    rs1 = 5'd9;
    tick();
    check("ar_first_cap", {27'd0, alu_rd}, 32'd4);
    check("ar_rso1", rso1, 32'd0);
    check("ar_cnt_rel", wb_commit_cnt, 32'd0);
    idle();
    tick();
    check("ar_cnt_one", wb_commit_cnt, 32'd1);

    // counter wrap via backdoor preload
    @(negedge clk);
    dut.wb_commit_cnt = 32'hFFFF_FFFF;
    #1;
    check("wrap_preload", wb_commit_cnt, 32'hFFFF_FFFF);
    drive(1'b1, 1'b1, 5'd13, 32'h0000_0D0D);
    tick();
    idle();
    tick();
    rs1 = 5'd13;
    #1;
    check("wrap_cnt", wb_commit_cnt, 32'd0);
    check("wrap_rso1", rso1, 32'h0000_0D0D);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
